// File: rtl/vga_scanout.sv
// VGA timing generator and framebuffer scan-out with configurable timing, pixel scaling,
// test patterns and a pipeline aligned to the framebuffer read latency.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int CW       = 4,
  parameter int ADDR_W   = 19,
  parameter int RD_LAT   = 1,
  parameter int SCALE_SH = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   doutb,
  output logic [ADDR_W-1:0] addrb,
  output logic [CW-1:0]     redout,
  output logic [CW-1:0]     greenout,
  output logic [CW-1:0]     blueout,
  output logic              H,
  output logic              V,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DLY     = RD_LAT + 1;

  localparam logic [HW-1:0] HA   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS0  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS1  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] HMAX = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] VA   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] VMAX = VW'(V_TOTAL - 1);

  localparam logic [ADDR_W-1:0] LB_STEP = ADDR_W'(H_ACTIVE >> SCALE_SH);
  localparam logic [VW-1:0]     SMASK   = VW'((1 << SCALE_SH) - 1);
  localparam logic              POL     = 1'(SYNC_POL);

  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       first;
    logic [1:0] mode;
    logic [2:0] bar;
    logic       chk;
  } pix_t;

  logic [HW-1:0]     r_hcnt;
  logic [VW-1:0]     r_vcnt;
  logic [ADDR_W-1:0] r_line_base;
  logic [VW-1:0]     w_vnext;
  logic [HW-1:0]     w_hsc;
  pix_t              w_s0;
  pix_t              r_pipe [DLY];
  pix_t              w_d;
  logic [3*CW-1:0]   w_rgb;

  assign w_vnext = r_vcnt + VW'(1);
  assign w_hsc   = r_hcnt >> SCALE_SH;
  assign w_d     = r_pipe[DLY-1];

  always_comb begin
    w_s0       = '0;
    w_s0.act   = (r_hcnt < HA) && (r_vcnt < VA);
    w_s0.hs    = (r_hcnt >= HS0) && (r_hcnt < HS1);
    w_s0.vs    = (r_vcnt >= VS0) && (r_vcnt < VS1);
    w_s0.first = (r_hcnt == '0) && (r_vcnt == '0);
    w_s0.mode  = mode;
    w_s0.chk   = (|((r_hcnt >> 5) & HW'(1))) ^ (|((r_vcnt >> 5) & VW'(1)));
    // Bar index hcnt*8/H_ACTIVE via threshold compares against k*H_ACTIVE
    for (int unsigned k = 1; k < 8; k++) begin
      if ({r_hcnt, 3'b000} >= (HW+3)'(k * H_ACTIVE))
        w_s0.bar = w_s0.bar + 3'd1;
    end
  end

  always_comb begin
    w_rgb = '0;
    if (w_d.act) begin
      case (w_d.mode)
        2'd0:    w_rgb = doutb;
        2'd1:    w_rgb = {{CW{w_d.bar[2]}}, {CW{w_d.bar[1]}}, {CW{w_d.bar[0]}}};
        2'd2:    w_rgb = {(3*CW){w_d.chk}};
        default: w_rgb = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      r_hcnt      <= '0;
      r_vcnt      <= '0;
      r_line_base <= '0;
      for (int unsigned i = 0; i < DLY; i++) r_pipe[i] <= '0;
      redout      <= '0;
      greenout    <= '0;
      blueout     <= '0;
      de          <= 1'b0;
      frame_start <= 1'b0;
      H           <= ~POL;
      V           <= ~POL;
      if (!rst) addrb <= '0;
    end else begin
      if (r_hcnt == HMAX) begin
        r_hcnt <= '0;
        if (r_vcnt == VMAX) begin
          r_vcnt      <= '0;
          r_line_base <= '0;
        end else begin
          r_vcnt <= w_vnext;
          // Line base advances once per replicated source row
          if ((w_vnext & SMASK) == '0) r_line_base <= r_line_base + LB_STEP;
        end
      end else begin
        r_hcnt <= r_hcnt + HW'(1);
      end

      if (w_s0.act) addrb <= ADDR_W'(w_hsc) + r_line_base;

      r_pipe[0] <= w_s0;
      for (int unsigned i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];

      redout      <= w_rgb[3*CW-1 -: CW];
      greenout    <= w_rgb[2*CW-1 -: CW];
      blueout     <= w_rgb[CW-1 -: CW];
      de          <= w_d.act;
      frame_start <= w_d.act && w_d.first;
      H           <= w_d.hs ? POL : ~POL;
      V           <= w_d.vs ? POL : ~POL;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a frame-level reference model pushes expected
// outputs per clock; a monitor pops and compares after each rising edge.
module tb_vga_scanout;

  localparam int HA = 64, HF = 4, HSY = 8, HB = 4;
  localparam int VA = 40, VF = 2, VSY = 2, VB = 3;
  localparam int RL = 2, SS = 1, AW = 12;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int PIPE = RL + 2;

  typedef struct packed {
    logic [11:0]   rgb;
    logic          h;
    logic          v;
    logic          de;
    logic          fs;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [11:0]   doutb;
  logic [AW-1:0] addrb;
  logic [3:0]    redout, greenout, blueout;
  logic          H, V, de, frame_start;

  logic [11:0]   mem_q [RL];

  exp_t          sb[$];
  exp_t          mq[$];
  int            mx = 0, my = 0;
  logic [AW-1:0] maddr = '0;
  logic [1:0]    cur_mode = 2'd0;
  int            checks = 0, errors = 0;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(0), .CW(4), .ADDR_W(AW), .RD_LAT(RL), .SCALE_SH(SS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .doutb(doutb), .addrb(addrb),
    .redout(redout), .greenout(greenout), .blueout(blueout),
    .H(H), .V(V), .de(de), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer: contents are a scramble of the address, read latency RL clocks
  always @(posedge clk) begin
    mem_q[0] <= addrb ^ 12'hA5C;
    for (int i = 1; i < RL; i++) mem_q[i] <= mem_q[i-1];
  end
  assign doutb = mem_q[RL-1];

  function automatic exp_t idle_px();
    exp_t p;
    p.rgb = '0; p.h = 1'b1; p.v = 1'b1; p.de = 1'b0; p.fs = 1'b0; p.addr = '0;
    return p;
  endfunction

  function automatic int addr_of(int x, int y);
    return (x >> SS) + (y >> SS) * (HA >> SS);
  endfunction

  function automatic exp_t pixel(int x, int y, logic [1:0] m);
    exp_t p;
    int k;
    logic [2:0] kb;
    bit act, hs, vs;
    act = (x < HA) && (y < VA);
    hs  = (x >= HA + HF) && (x < HA + HF + HSY);
    vs  = (y >= VA + VF) && (y < VA + VF + VSY);
    p = idle_px();
    p.h = !hs;
    p.v = !vs;
    if (act) begin
      p.de = 1'b1;
      p.fs = (x == 0) && (y == 0);
      case (m)
        2'd0: p.rgb = 12'(addr_of(x, y)) ^ 12'hA5C;
        2'd1: begin
          k  = x * 8 / HA;
          kb = 3'(k);
          p.rgb = {{4{kb[2]}}, {4{kb[1]}}, {4{kb[0]}}};
        end
        2'd2: p.rgb = ((((x / 32) + (y / 32)) % 2) == 1) ? 12'hFFF : 12'h000;
        default: p.rgb = '0;
      endcase
    end
    return p;
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m);
    exp_t o;
    rst = r; en = e; mode = m;
    if (!r || !e) begin
      if (!r) maddr = '0;
      mq.delete();
      for (int i = 0; i < PIPE - 1; i++) mq.push_back(idle_px());
      o = idle_px();
      mx = 0; my = 0;
    end else begin
      if (mx < HA && my < VA) maddr = AW'(addr_of(mx, my));
      mq.push_back(pixel(mx, my, m));
      o = mq.pop_front();
      mx++;
      if (mx == HT) begin
        mx = 0;
        my++;
        if (my == VT) my = 0;
      end
    end
    o.addr = maddr;
    sb.push_back(o);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    int left = 0;
    for (int i = 0; i < n; i++) begin
      if (left == 0) begin
        cur_mode = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        left = $urandom_range(20, 300);
      end
      left--;
      step(1'b1, 1'b1, cur_mode);
    end
  endtask

  task automatic run_fixed(input logic [1:0] m, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, m);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({redout, greenout, blueout, H, V, de, frame_start} !== {e.rgb, e.h, e.v, e.de, e.fs}) begin
        errors++;
        $display("FAIL outs t=%0t got rgb=%h H=%b V=%b de=%b fs=%b exp rgb=%h H=%b V=%b de=%b fs=%b",
                 $time, {redout, greenout, blueout}, H, V, de, frame_start,
                 e.rgb, e.h, e.v, e.de, e.fs);
      end
      checks++;
      if (addrb !== e.addr) begin
        errors++;
        $display("FAIL addrb t=%0t got %0d exp %0d", $time, addrb, e.addr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 2'd0);
    run_fixed(2'd0, HT * VT + 10);
    run_fixed(2'd1, HT * 2);
    run_fixed(2'd2, HT * VT);
    run_fixed(2'd3, HT);
    run(HT * 10 + 17);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, cur_mode);
    run(HT * VT + HT * 20 + 33);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, cur_mode);
    run(HT * VT + 200);
    step(1'b0, 1'b1, 2'd0);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Parametrised VGA timing generator and frame-buffer scan-out engine, successor to the fixed 640x480 controller. It drives the framebuffer read port (addrb/doutb) and produces HSYNC/VSYNC/RGB pixel-aligned to the memory read latency. Adds configurable timing and sync polarity, integer pixel scaling, a blanking-correct data-enable, a frame-start strobe, and built-in test patterns. Sits between the k-means result framebuffer BRAM and the board VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
SYNC_POL, 0, active level of H and V (0 = active-low)
CW, 4, bits per colour channel
ADDR_W, 19, framebuffer address width
RD_LAT, 1, framebuffer read latency in clocks (addrb to doutb), 1..4
SCALE_SH, 0, pixel replication shift (0 = 1x, 1 = 2x, 2 = 4x) in both axes

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous active-low reset, sampled on rising clk
en  in  1  scan enable; low holds timing idle
mode  in  2  0 framebuffer, 1 eight vertical colour bars, 2 checkerboard, 3 solid black
doutb  in  3*CW  framebuffer read data, packed {R,G,B}, MSB first
addrb  out  ADDR_W  framebuffer read address
redout  out  CW  red
greenout  out  CW  green
blueout  out  CW  blue
H  out  1  horizontal sync
V  out  1  vertical sync
de  out  1  data enable (visible pixel on outputs)
frame_start  out  1  one-cycle pulse with first visible pixel of each frame

Behaviour:
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525). Line order: active, front porch, sync, back porch.
- hcnt 0..H_TOTAL-1 increments every clk when en=1; at H_TOTAL-1 wraps to 0 and vcnt increments; vcnt wraps from V_TOTAL-1 to 0 at the same clk hcnt wraps.
- Stage-0 signals from counters: act = (hcnt<H_ACTIVE)&&(vcnt<V_ACTIVE); hs = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vs = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- addrb registered: when act, addrb <= (hcnt>>SCALE_SH) + (vcnt>>SCALE_SH)*(H_ACTIVE>>SCALE_SH), truncated to ADDR_W; when not act, addrb holds. Multiplier-free (running line base) implementation required.
- Pipeline depth PIPE = RD_LAT+2: act/hs/vs/pattern-select delayed through PIPE register stages so outputs for counter value n appear exactly PIPE clocks later, aligned with doutb for that address.
- Output stage (registered): if delayed act=0 -> RGB=0, de=0. Else mode 0: RGB=doutb fields; mode 1: bar index = hcnt*8/H_ACTIVE (hcnt>>? not required, compare thresholds), bar k colour = {R=k[2],G=k[1],B=k[0]} each replicated to full-scale (all-ones or zero); mode 2: white when hcnt[5]^vcnt[5] else black; mode 3: black. de=1.
- H = delayed hs ? SYNC_POL : ~SYNC_POL; V likewise.
- frame_start = 1 for one clk when the delayed pixel is hcnt=0,vcnt=0 and visible.
- mode sampled at stage 0 and carried down the pipe; a change mid-line takes effect on the next pixel, no glitch on syncs.
- en=0: counters and pipe cleared to idle on next clk; RGB=0, de=0, frame_start=0, H/V at inactive level, addrb holds. On en rising, hcnt=vcnt=0 and first visible pixel emerges PIPE clocks later with frame_start.
- rst=0 at a clk edge (also mid-frame): hcnt=vcnt=0, all pipe stages idle, addrb=0, RGB=0, de=0, frame_start=0, H=V=~SYNC_POL. Takes priority over en.
- Sync and de widths are exact: H active H_SYNC clks per line, V active V_SYNC*H_TOTAL clks per frame, de high H_ACTIVE clks per visible line.

Test Plan:
- Reset/idle: rst=0 3 clks, then rst=1 en=0 -> H=V=1, RGB=0, de=0, addrb=0 throughout.
- Timing, defaults, en=1 from reset release (clk 0): de first high at clk 3 with frame_start=1; H low clks 659..754 of line 0 (96 clks); V low for lines 490-491; period 800 x 525 = 420000 clks between frame_start pulses.
- Address/latency: doutb model = addrb low 12 bits delayed 1 clk -> visible pixel (x,y) outputs {R,G,B} = (x+640y)[11:0]; pixel (639,479) addr 307199.
- Scaling SCALE_SH=1: addrb for (x,y)=(5,3) is 2+1*320=322; each address repeats 2 pixels and 2 lines.
- Patterns: mode=1 -> pixels 0-79 black, 80-159 blue (0,0,F), 560-639 white; mode=2 pixel (32,0) white, (32,32) black; switch mode mid-line -> change after exactly PIPE clks, H unaffected.
- Mid-frame reset at line 200 and en drop at line 100 -> outputs idle next clk; after release, next frame_start exactly PIPE clks later.
